// File: rtl/fetch_predict_pipeline.sv
// Instruction fetch stage with a 2-bit saturating-counter branch predictor.
// Holds the PC, registers the fetched word into the IF/ID latch and accepts resolve redirects.
module fetch_predict_pipeline #(
   parameter logic [31:0] RESET_PC  = 32'h0,
   parameter int unsigned BHT_IDX_W = 4,
   parameter int unsigned CNT_W     = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   output logic [31:0]      imem_addr,
   input  logic [31:0]      imem_data,
   output logic [31:0]      instr_out,
   output logic [31:0]      current_PC,
   output logic             instr_valid,
   output logic             pred_taken,
   input  logic             resolve_valid,
   input  logic [31:0]      resolve_PC,
   input  logic             resolve_taken,
   input  logic             resolve_pred,
   input  logic [31:0]      resolve_target,
   output logic [CNT_W-1:0] branch_count,
   output logic [CNT_W-1:0] mispred_count
);

   localparam int BhtEntries = 1 << BHT_IDX_W;

   logic [31:0]      pc_q, pc_d;
   logic [31:0]      instr_q, instr_d;
   logic [31:0]      cur_pc_q, cur_pc_d;
   logic             valid_q, valid_d;
   logic             pred_q, pred_d;
   logic [1:0]       bht_q [BhtEntries];
   logic [1:0]       bht_d [BhtEntries];
   logic [CNT_W-1:0] branch_q, branch_d;
   logic [CNT_W-1:0] mispred_q, mispred_d;

   logic [6:0]           opcode;
   logic                 is_bne, is_jump;
   logic [BHT_IDX_W-1:0] fetch_idx, resolve_idx;
   logic                 fetch_taken;
   logic [31:0]          fetch_target, next_pc;
   logic                 mispredict;

   assign opcode      = imem_data[6:0];
   assign is_bne      = (opcode == 7'b1100011) && (imem_data[14:12] == 3'b001);
   assign is_jump     = (opcode == 7'b0110111);
   assign fetch_idx   = pc_q[BHT_IDX_W+1:2];
   assign resolve_idx = resolve_PC[BHT_IDX_W+1:2];
   assign mispredict  = resolve_valid && (resolve_taken != resolve_pred);

   // Prediction reads the pre-update counter even if the same entry trains this cycle.
   always_comb begin
      fetch_taken  = is_jump || (is_bne && bht_q[fetch_idx][1]);
      fetch_target = is_jump ? {12'b0, imem_data[31:12]}
                             : {20'b0, imem_data[31:25], imem_data[11:7]};
      next_pc      = fetch_taken ? fetch_target : pc_q + 32'd4;
   end

   // Redirect from a mispredict wins over a decode stall and inserts a bubble.
   always_comb begin
      pc_d     = pc_q;
      instr_d  = instr_q;
      cur_pc_d = cur_pc_q;
      valid_d  = valid_q;
      pred_d   = pred_q;
      if (mispredict) begin
         pc_d    = resolve_taken ? resolve_target : resolve_PC + 32'd4;
         instr_d = 32'h0;
         valid_d = 1'b0;
         pred_d  = 1'b0;
      end else if (!stall) begin
         pc_d     = next_pc;
         instr_d  = imem_data;
         cur_pc_d = pc_q;
         valid_d  = 1'b1;
         pred_d   = fetch_taken;
      end
   end

   always_comb begin
      bht_d = bht_q;
      if (resolve_valid) begin
         if (resolve_taken) begin
            if (bht_q[resolve_idx] != 2'b11) bht_d[resolve_idx] = bht_q[resolve_idx] + 2'd1;
         end else begin
            if (bht_q[resolve_idx] != 2'b00) bht_d[resolve_idx] = bht_q[resolve_idx] - 2'd1;
         end
      end
   end

   always_comb begin
      branch_d  = branch_q;
      mispred_d = mispred_q;
      if (resolve_valid && (branch_q != '1)) branch_d = branch_q + 1'b1;
      if (mispredict && (mispred_q != '1))   mispred_d = mispred_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q      <= RESET_PC;
         instr_q   <= 32'h0;
         cur_pc_q  <= 32'h0;
         valid_q   <= 1'b0;
         pred_q    <= 1'b0;
         branch_q  <= '0;
         mispred_q <= '0;
         for (int i = 0; i < BhtEntries; i++) bht_q[i] <= 2'b01;
      end else begin
         pc_q      <= pc_d;
         instr_q   <= instr_d;
         cur_pc_q  <= cur_pc_d;
         valid_q   <= valid_d;
         pred_q    <= pred_d;
         branch_q  <= branch_d;
         mispred_q <= mispred_d;
         bht_q     <= bht_d;
      end
   end

   assign imem_addr     = pc_q;
   assign instr_out     = instr_q;
   assign current_PC    = cur_pc_q;
   assign instr_valid   = valid_q;
   assign pred_taken    = pred_q;
   assign branch_count  = branch_q;
   assign mispred_count = mispred_q;

endmodule
